l1i_refill_unit: RTL and testbench

//  Miss handler directly downstream of the L1 instruction cache miss port and upstream of its update port.

---
 rtl/l1i_refill_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_l1i_refill_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1i_refill_unit.sv
// L1 instruction-cache refill unit.
// Takes one miss at a time from the L1I and sends a line-aligned request to L2/memory.
// It then gathers two consecutive cache lines of response beats: the missed line and
// the next sequential line. It returns them to the cache with a single-cycle update strobe.
module l1i_refill_unit #(
  parameter int fetchingAddressWidth    = 64,
  parameter int cacheLineWith           = 512,
  parameter int offsetWidth             = 6,
  parameter int beatWidth               = 128,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               flush_i,
  // miss port from the L1I
  input  logic                               cacheMiss_i,
  input  logic [fetchingAddressWidth-1:0]    missedAddress_i,
  input  logic [instructionCounterWidth-1:0] missedInstMajorId_i,
  input  logic [PidSize-1:0]                 missedPid_i,
  input  logic [TidSize-1:0]                 missedTid_i,
  // request channel to L2/memory
  output logic                               memReqValid_o,
  input  logic                               memReqReady_i,
  output logic [fetchingAddressWidth-1:0]    memReqAddress_o,
  output logic [PidSize-1:0]                 memReqPid_o,
  output logic [TidSize-1:0]                 memReqTid_o,
  // response beats from L2/memory
  input  logic                               memRespValid_i,
  input  logic [beatWidth-1:0]               memRespData_i,
  output logic                               memRespReady_o,
  // update port back into the L1I
  output logic                               cacheUpdate_o,
  output logic [fetchingAddressWidth-1:0]    cacheUpdateAddress_o,
  output logic [cacheLineWith-1:0]           cacheUpdateLine1_o,
  output logic [cacheLineWith-1:0]           cacheUpdateLine2_o,
  output logic [PidSize-1:0]                 cacheUpdatePid_o,
  output logic [TidSize-1:0]                 cacheUpdateTid_o,
  output logic [instructionCounterWidth-1:0] fillInstMajorId_o,
  output logic                               busy_o
);

  // Two lines are fetched per miss. beatWidth must divide cacheLineWith.
  localparam int BeatsPerFill = 2 * cacheLineWith / beatWidth;
  localparam int BeatCntWidth = (BeatsPerFill > 1) ? $clog2(BeatsPerFill) : 1;
  localparam int FillWidth    = 2 * cacheLineWith;

  // Mask of the line-offset bits. They are cleared to form the request address.
  localparam logic [fetchingAddressWidth-1:0] OffsetMask =
    fetchingAddressWidth'((64'd1 << offsetWidth) - 64'd1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_FILL,
    ST_UPDATE
  } state_e;

  state_e                             state_q;
  logic                               miss_prev_q;
  logic                               drop_q;
  logic [BeatCntWidth-1:0]            beat_cnt_q;

  // Staging buffer for both lines.
  // Slot 0 is at the most-significant end, so Line1 = {beat0, beat1, ...}.
  logic [FillWidth-1:0]               fill_q;
  logic [FillWidth-1:0]               fill_d;

  // Captured miss: drives the request channel and later the update port.
  logic                               req_valid_q;
  logic [fetchingAddressWidth-1:0]    req_addr_q;
  logic [PidSize-1:0]                 req_pid_q;
  logic [TidSize-1:0]                 req_tid_q;
  logic [instructionCounterWidth-1:0] req_id_q;

  logic                               resp_ready_q;
  logic                               busy_q;

  // Update-port registers. They are only reloaded when a fill completes undropped.
  // Between fills they hold the last delivered values.
  logic                               upd_q;
  logic [fetchingAddressWidth-1:0]    upd_addr_q;
  logic [cacheLineWith-1:0]           upd_line1_q;
  logic [cacheLineWith-1:0]           upd_line2_q;
  logic [PidSize-1:0]                 upd_pid_q;
  logic [TidSize-1:0]                 upd_tid_q;
  logic [instructionCounterWidth-1:0] upd_id_q;

  logic                               miss_edge;
  logic                               beat_fire;
  logic                               last_beat;
  logic                               drop_d;
  logic [BeatsPerFill-1:0]            slot_hit;

  // A miss only counts on its rising edge. A concurrent flush suppresses it.
  assign miss_edge = cacheMiss_i & ~miss_prev_q & ~flush_i;
  assign beat_fire = (state_q == ST_FILL) & memRespValid_i;
  assign last_beat = (beat_cnt_q == BeatCntWidth'(BeatsPerFill - 1));
  // A flush arriving together with the final beat must still suppress the update.
  assign drop_d    = drop_q | flush_i;

  // Route the incoming beat into its slot of the staging buffer.
  // Slots are placed big-endian.
  genvar gi;
  generate
    for (gi = 0; gi < BeatsPerFill; gi++) begin : g_slot
      assign slot_hit[gi] = beat_fire & (beat_cnt_q == BeatCntWidth'(gi));
      assign fill_d[(BeatsPerFill-1-gi)*beatWidth +: beatWidth] =
        slot_hit[gi] ? memRespData_i
                     : fill_q[(BeatsPerFill-1-gi)*beatWidth +: beatWidth];
    end
  endgenerate

  // Miss-handling FSM with all outputs registered.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      miss_prev_q  <= 1'b0;
      drop_q       <= 1'b0;
      beat_cnt_q   <= '0;
      fill_q       <= '0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      req_pid_q    <= '0;
      req_tid_q    <= '0;
      req_id_q     <= '0;
      resp_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      upd_q        <= 1'b0;
      upd_addr_q   <= '0;
      upd_line1_q  <= '0;
      upd_line2_q  <= '0;
      upd_pid_q    <= '0;
      upd_tid_q    <= '0;
      upd_id_q     <= '0;
    end else begin
      miss_prev_q <= cacheMiss_i;
      upd_q       <= 1'b0;
      fill_q      <= fill_d;

      case (state_q)
        ST_IDLE: begin
          if (miss_edge) begin
            req_addr_q  <= missedAddress_i & ~OffsetMask;
            req_pid_q   <= missedPid_i;
            req_tid_q   <= missedTid_i;
            req_id_q    <= missedInstMajorId_i;
            req_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (memReqReady_i) begin
            // Once the handshake happens the request is out.
            // A simultaneous flush only marks the returning data as unwanted.
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b1;
            beat_cnt_q   <= '0;
            drop_q       <= flush_i;
            state_q      <= ST_FILL;
          end else if (flush_i) begin
            req_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        ST_FILL: begin
          // Keep draining after a flush so the response stream stays aligned.
          drop_q <= drop_d;
          if (beat_fire) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (last_beat) begin
              resp_ready_q <= 1'b0;
              upd_q        <= ~drop_d;
              state_q      <= ST_UPDATE;
              if (!drop_d) begin
                upd_addr_q  <= req_addr_q;
                upd_line1_q <= fill_d[FillWidth-1:cacheLineWith];
                upd_line2_q <= fill_d[cacheLineWith-1:0];
                upd_pid_q   <= req_pid_q;
                upd_tid_q   <= req_tid_q;
                upd_id_q    <= req_id_q;
              end
            end
          end
        end

        ST_UPDATE: begin
          drop_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q      <= ST_IDLE;
          req_valid_q  <= 1'b0;
          resp_ready_q <= 1'b0;
          busy_q       <= 1'b0;
          drop_q       <= 1'b0;
        end
      endcase
    end
  end

  assign memReqValid_o        = req_valid_q;
  assign memReqAddress_o      = req_addr_q;
  assign memReqPid_o          = req_pid_q;
  assign memReqTid_o          = req_tid_q;
  assign memRespReady_o       = resp_ready_q;
  assign cacheUpdate_o        = upd_q;
  assign cacheUpdateAddress_o = upd_addr_q;
  assign cacheUpdateLine1_o   = upd_line1_q;
  assign cacheUpdateLine2_o   = upd_line2_q;
  assign cacheUpdatePid_o     = upd_pid_q;
  assign cacheUpdateTid_o     = upd_tid_q;
  assign fillInstMajorId_o    = upd_id_q;
  assign busy_o               = busy_q;

endmodule

// File: tb/tb_l1i_refill_unit.sv
// Self-checking bench for l1i_refill_unit.
// Each miss is driven as a transaction. The bench predicts the outcome from the transaction
// itself: the aligned request address, the beats concatenated into two lines, and whether
// an update is expected.
module tb_l1i_refill_unit;

  localparam int NB = 8;  // beats per fill with the default parameters

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          flush_i;
  logic          cacheMiss_i;
  logic [63:0]   missedAddress_i;
  logic [63:0]   missedInstMajorId_i;
  logic [19:0]   missedPid_i;
  logic [15:0]   missedTid_i;
  logic          memReqValid_o;
  logic          memReqReady_i;
  logic [63:0]   memReqAddress_o;
  logic [19:0]   memReqPid_o;
  logic [15:0]   memReqTid_o;
  logic          memRespValid_i;
  logic [127:0]  memRespData_i;
  logic          memRespReady_o;
  logic          cacheUpdate_o;
  logic [63:0]   cacheUpdateAddress_o;
  logic [511:0]  cacheUpdateLine1_o;
  logic [511:0]  cacheUpdateLine2_o;
  logic [19:0]   cacheUpdatePid_o;
  logic [15:0]   cacheUpdateTid_o;
  logic [63:0]   fillInstMajorId_o;
  logic          busy_o;

  l1i_refill_unit dut (
    .clock_i              (clock_i),
    .reset_i              (reset_i),
    .flush_i              (flush_i),
    .cacheMiss_i          (cacheMiss_i),
    .missedAddress_i      (missedAddress_i),
    .missedInstMajorId_i  (missedInstMajorId_i),
    .missedPid_i          (missedPid_i),
    .missedTid_i          (missedTid_i),
    .memReqValid_o        (memReqValid_o),
    .memReqReady_i        (memReqReady_i),
    .memReqAddress_o      (memReqAddress_o),
    .memReqPid_o          (memReqPid_o),
    .memReqTid_o          (memReqTid_o),
    .memRespValid_i       (memRespValid_i),
    .memRespData_i        (memRespData_i),
    .memRespReady_o       (memRespReady_o),
    .cacheUpdate_o        (cacheUpdate_o),
    .cacheUpdateAddress_o (cacheUpdateAddress_o),
    .cacheUpdateLine1_o   (cacheUpdateLine1_o),
    .cacheUpdateLine2_o   (cacheUpdateLine2_o),
    .cacheUpdatePid_o     (cacheUpdatePid_o),
    .cacheUpdateTid_o     (cacheUpdateTid_o),
    .fillInstMajorId_o    (fillInstMajorId_o),
    .busy_o               (busy_o)
  );

  always #5 clock_i = ~clock_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int miss_left = 0;
  int req_count = 0;
  int upd_count = 0;

  typedef struct {
    logic [63:0] addr;
    logic [19:0] pid;
    logic [15:0] tid;
    logic [63:0] id;
    int          stall;     // cycles memReqReady_i is held low while the request is valid
    int          gap;       // 0 back-to-back, 1 alternating 1010, 2 random
    int          flush_at;  // flush while presenting the beat after this index; -1 none
    int          hold;      // cycles cacheMiss_i stays high
    logic [63:0] exp_addr;
    bit          exp_upd;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic outs_nonzero();
    return memReqValid_o | memRespReady_o | cacheUpdate_o | busy_o |
           (|memReqAddress_o) | (|memReqPid_o) | (|memReqTid_o) |
           (|cacheUpdateAddress_o) | (|cacheUpdateLine1_o) | (|cacheUpdateLine2_o) |
           (|cacheUpdatePid_o) | (|cacheUpdateTid_o) | (|fillInstMajorId_o);
  endfunction

  // Advance one clock. Handshakes and strobes are recorded and cacheMiss_i is aged.
  task automatic step();
    bit hs;
    hs = memReqValid_o && memReqReady_i;
    @(posedge clock_i);
    #1;
    cyc++;
    if (hs) req_count++;
    if (cacheUpdate_o) upd_count++;
    if (miss_left > 0) miss_left--;
    cacheMiss_i = (miss_left > 0);
  endtask

  task automatic run_miss(input logic [63:0] addr, input logic [19:0] pid,
                          input logic [15:0] tid, input logic [63:0] id,
                          input int stall, input int gap, input int flush_at,
                          input int hold, input logic [63:0] exp_addr, input bit exp_upd);
    logic [127:0] beats [NB];
    logic [511:0] exp_l1;
    logic [511:0] exp_l2;
    int c0, nsent, budget, req0, upd0;
    bit stable_ok, acc, flushed, v;
    for (int k = 0; k < NB; k++) beats[k] = {$urandom, $urandom, $urandom, $urandom};
    exp_l1 = {beats[0], beats[1], beats[2], beats[3]};
    exp_l2 = {beats[4], beats[5], beats[6], beats[7]};
    req0 = req_count;
    upd0 = upd_count;

    missedAddress_i     = addr;
    missedPid_i         = pid;
    missedTid_i         = tid;
    missedInstMajorId_i = id;
    cacheMiss_i         = 1'b1;
    miss_left           = hold;
    memReqReady_i       = (stall == 0);
    c0 = cyc;
    step();
    chk("req_valid_latency", memReqValid_o, 1'b1);
    chk("req_addr", memReqAddress_o, exp_addr);
    chk("req_pid", memReqPid_o, pid);
    chk("req_tid", memReqTid_o, tid);
    // Change the miss inputs so later checks see only the captured copy.
    missedAddress_i     = ~addr;
    missedPid_i         = ~pid;
    missedTid_i         = ~tid;
    missedInstMajorId_i = ~id;

    stable_ok = 1'b1;
    for (int s = 0; s < stall; s++) begin
      step();
      if (!(memReqValid_o === 1'b1 && memReqAddress_o === exp_addr &&
            memReqPid_o === pid && memReqTid_o === tid)) stable_ok = 1'b0;
    end
    if (stall > 0) chk("req_stable_while_stalled", stable_ok, 1'b1);
    memReqReady_i = 1'b1;
    step();
    memReqReady_i = 1'b0;
    chk("req_accepted_once", req_count - req0, 1);
    chk("resp_ready_in_fill", memRespReady_o, 1'b1);

    nsent = 0;
    budget = 0;
    flushed = 1'b0;
    while (nsent < NB && budget < 300) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = (budget % 2 == 0);
        default: v = ($urandom_range(0, 1) == 1);
      endcase
      memRespValid_i = v;
      memRespData_i  = v ? beats[nsent] : {$urandom, $urandom, $urandom, $urandom};
      flush_i = (flush_at >= 0 && nsent == flush_at + 1 && !flushed);
      if (flush_i) flushed = 1'b1;
      acc = memRespValid_i && memRespReady_o;
      step();
      budget++;
      if (acc) nsent++;
    end
    memRespValid_i = 1'b0;
    flush_i = 1'b0;
    chk("beats_accepted", nsent, NB);
    chk("update_strobe", cacheUpdate_o, exp_upd);
    chk("busy_in_update", busy_o, 1'b1);
    if (exp_upd) begin
      chk("line1", cacheUpdateLine1_o, exp_l1);
      chk("line2", cacheUpdateLine2_o, exp_l2);
      chk("update_addr", cacheUpdateAddress_o, exp_addr);
      chk("update_pid", cacheUpdatePid_o, pid);
      chk("update_tid", cacheUpdateTid_o, tid);
      chk("update_id", fillInstMajorId_o, id);
      if (stall == 0 && gap == 0) chk("miss_to_update_cycles", cyc - c0, 10);
    end
    step();
    chk("update_strobe_off", cacheUpdate_o, 1'b0);
    chk("busy_after_update", busy_o, 1'b0);
    if (exp_upd) chk("line1_held", cacheUpdateLine1_o, exp_l1);
    while (miss_left > 0) step();
    step();
    step();
    chk("single_request", req_count - req0, 1);
    chk("update_count", upd_count - upd0, exp_upd ? 1 : 0);
    $display("txn addr=%h pid=%0d tid=%0d stall=%0d gap=%0d flush_at=%0d hold=%0d updates=%0d",
             addr, pid, tid, stall, gap, flush_at, hold, upd_count - upd0);
  endtask

  initial begin
    logic [63:0] ra;
    int fa;

    vecs[0] = '{64'h4, 20'd5, 16'd2, 64'h11, 0, 0, -1, 1, 64'h0, 1'b1};
    vecs[1] = '{64'h1234_5678_9ABC_DEF0, 20'hABCDE, 16'h1111, 64'hCAFE, 4, 0, -1, 1,
                64'h1234_5678_9ABC_DEC0, 1'b1};
    vecs[2] = '{64'h8000, 20'd7, 16'd3, 64'h22, 1, 1, -1, 1, 64'h8000, 1'b1};
    vecs[3] = '{64'h1F8, 20'd9, 16'd4, 64'h33, 0, 0, -1, 20, 64'h1C0, 1'b1};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 20'hFFFFF, 16'hFFFF, 64'h44, 2, 1, 2, 1,
                64'hFFFF_FFFF_FFFF_FFC0, 1'b0};
    vecs[5] = '{64'h40, 20'd1, 16'd1, 64'h55, 0, 0, -1, 1, 64'h40, 1'b1};

    reset_i = 1'b1;
    flush_i = 1'b0;
    cacheMiss_i = 1'b0;
    missedAddress_i = '0;
    missedInstMajorId_i = '0;
    missedPid_i = '0;
    missedTid_i = '0;
    memReqReady_i = 1'b0;
    memRespValid_i = 1'b0;
    memRespData_i = '0;
    step();
    step();
    chk("reset_outputs_zero", outs_nonzero(), 1'b0);
    reset_i = 1'b0;
    step();

    // Table-driven transactions.
    for (int i = 0; i < 6; i++)
      run_miss(vecs[i].addr, vecs[i].pid, vecs[i].tid, vecs[i].id, vecs[i].stall,
               vecs[i].gap, vecs[i].flush_at, vecs[i].hold, vecs[i].exp_addr, vecs[i].exp_upd);

    // Reset during FILL after three beats.
    missedAddress_i = 64'h2000;
    missedPid_i = 20'd3;
    missedTid_i = 16'd6;
    missedInstMajorId_i = 64'h77;
    cacheMiss_i = 1'b1;
    miss_left = 1;
    memReqReady_i = 1'b1;
    step();
    step();
    memReqReady_i = 1'b0;
    chk("fill_before_reset", memRespReady_o, 1'b1);
    for (int b = 0; b < 3; b++) begin
      memRespValid_i = 1'b1;
      memRespData_i = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    memRespValid_i = 1'b0;
    reset_i = 1'b1;
    #1;
    chk("async_reset_outputs_zero", outs_nonzero(), 1'b0);
    step();
    reset_i = 1'b0;
    step();
    chk("idle_after_reset", busy_o, 1'b0);
    run_miss(64'h3030, 20'd8, 16'd9, 64'h99, 0, 0, -1, 1, 64'h3000, 1'b1);

    // A flush while the request is pending abandons it.
    missedAddress_i = 64'h5000;
    cacheMiss_i = 1'b1;
    miss_left = 1;
    memReqReady_i = 1'b0;
    step();
    chk("req_pending", memReqValid_o, 1'b1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("req_flush_valid", memReqValid_o, 1'b0);
    chk("req_flush_busy", busy_o, 1'b0);

    // A miss edge coinciding with a flush in IDLE is not captured.
    cacheMiss_i = 1'b1;
    miss_left = 1;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    step();
    chk("flush_blocks_capture", busy_o, 1'b0);

    // Randomised transactions checked against the transaction-level prediction.
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) step();
      ra = {$urandom, $urandom};
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_miss(ra, 20'($urandom), 16'($urandom), {$urandom, $urandom},
               int'($urandom_range(0, 3)), 2, fa, int'($urandom_range(1, 3)),
               ra & ~64'h3F, (fa < 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
